// File: rtl/dac_instr_serializer.sv
// Holds the newest code for each DAC channel and sends pending updates round-robin as 32-bit SPI frames.
// Optional build macro DAC_LDAC_PULSE_EN: channel writes skip the update and a 2-cycle nLDAC pulse follows each channel frame.
module dac_instr_serializer #(
    parameter int N_CHAN   = 8,
    parameter int W_DATA   = 16,
    parameter int SCLK_DIV = 2,
    parameter int T_SYNC   = 4
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic [N_CHAN-1:0]        data_valid_in,
    input  logic [N_CHAN*W_DATA-1:0] data_in,
    input  logic                     ref_set_in,
    output logic                     dac_nsync_out,
    output logic                     dac_sclk_out,
    output logic                     dac_din_out,
    output logic                     dac_nldac_out,
    output logic                     dac_nclr_out,
    output logic                     wr_done_out,
    output logic                     busy_out
);
    localparam int PTR_W  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int DIV_W  = $clog2(SCLK_DIV + 1);
    localparam int SYNC_W = $clog2(T_SYNC + 1);
    localparam logic [31:0] REF_WORD = 32'h0800_0001;
`ifdef DAC_LDAC_PULSE_EN
    localparam logic [3:0] CTRL = 4'b0000;
`else
    localparam logic [3:0] CTRL = 4'b0011;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, SCLK_HI, SCLK_LO, SYNC_HIGH} state_t;

    state_t              state_reg;
    logic [N_CHAN-1:0]   pending_reg;
    logic                ref_pending_reg;
    logic [PTR_W-1:0]    ptr_reg;
    logic [30:0]         shift_reg;
    logic [4:0]          bit_cnt_reg;
    logic [DIV_W-1:0]    div_cnt_reg;
    logic [SYNC_W-1:0]   sync_cnt_reg;
    logic                nsync_reg, sclk_reg, din_reg, wr_done_reg, busy_reg;

    logic [W_DATA-1:0]   hold_word [N_CHAN];
    logic                grant_found;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    scan_idx;
    logic                ref_grant, chan_grant;
    logic [N_CHAN-1:0]   grant_mask;
    logic [31:0]         word;
    logic                div_last, frame_end;

    // Per-channel holding register: a strobe always overwrites, so only the newest code survives.
    for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
        logic [W_DATA-1:0] hold_reg;
        always_ff @(posedge clk_in) begin
            if (reset_in)
                hold_reg <= '0;
            else if (data_valid_in[gi])
                hold_reg <= data_in[gi*W_DATA +: W_DATA];
        end
        assign hold_word[gi] = hold_reg;
    end

    // Scan starts one past the last served channel so every requester waits at most N_CHAN-1 frames.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int i = 1; i <= N_CHAN; i++) begin
            scan_idx = PTR_W'((int'(ptr_reg) + i) % N_CHAN);
            if (!grant_found && pending_reg[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign ref_grant  = (state_reg == IDLE) && ref_pending_reg;
    assign chan_grant = (state_reg == IDLE) && !ref_pending_reg && grant_found;
    assign grant_mask = chan_grant ? (N_CHAN'(1) << grant_idx) : '0;
    assign word       = ref_pending_reg ? REF_WORD
                                        : {4'h0, CTRL, 4'(grant_idx), hold_word[grant_idx], 4'h0};
    assign div_last   = (div_cnt_reg == DIV_W'(SCLK_DIV - 1));
    assign frame_end  = (state_reg == SCLK_LO) && div_last && (bit_cnt_reg == 5'd31);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_reg       <= IDLE;
            pending_reg     <= '0;
            ref_pending_reg <= 1'b0;
            ptr_reg         <= PTR_W'(N_CHAN - 1);
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            div_cnt_reg     <= '0;
            sync_cnt_reg    <= '0;
            nsync_reg       <= 1'b1;
            sclk_reg        <= 1'b1;
            din_reg         <= 1'b0;
            wr_done_reg     <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            wr_done_reg     <= 1'b0;
            // A strobe landing on its own grant cycle re-arms the request rather than being lost.
            pending_reg     <= (pending_reg & ~grant_mask) | data_valid_in;
            ref_pending_reg <= (ref_pending_reg & ~ref_grant) | ref_set_in;
            case (state_reg)
                IDLE: begin
                    if (ref_grant || chan_grant) begin
                        state_reg   <= LOAD;
                        shift_reg   <= word[30:0];
                        din_reg     <= word[31];
                        nsync_reg   <= 1'b0;
                        busy_reg    <= 1'b1;
                        bit_cnt_reg <= '0;
                        if (chan_grant)
                            ptr_reg <= grant_idx;
                    end
                end
                // LOAD is the first cycle of bit 31's high phase, keeping nsync low for exactly 64*SCLK_DIV cycles.
                LOAD: begin
                    if (SCLK_DIV == 1) begin
                        state_reg   <= SCLK_LO;
                        sclk_reg    <= 1'b0;
                        div_cnt_reg <= '0;
                    end else begin
                        state_reg   <= SCLK_HI;
                        div_cnt_reg <= DIV_W'(1);
                    end
                end
                SCLK_HI: begin
                    if (div_last) begin
                        state_reg   <= SCLK_LO;
                        sclk_reg    <= 1'b0;
                        div_cnt_reg <= '0;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                SCLK_LO: begin
                    if (!div_last) begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end else if (frame_end) begin
                        state_reg    <= SYNC_HIGH;
                        sclk_reg     <= 1'b1;
                        nsync_reg    <= 1'b1;
                        wr_done_reg  <= 1'b1;
                        sync_cnt_reg <= '0;
                    end else begin
                        state_reg   <= SCLK_HI;
                        sclk_reg    <= 1'b1;
                        din_reg     <= shift_reg[30];
                        shift_reg   <= {shift_reg[29:0], 1'b0};
                        bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        div_cnt_reg <= '0;
                    end
                end
                SYNC_HIGH: begin
                    if (sync_cnt_reg == SYNC_W'(T_SYNC - 1)) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        din_reg   <= 1'b0;
                    end else begin
                        sync_cnt_reg <= sync_cnt_reg + SYNC_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef DAC_LDAC_PULSE_EN
    logic nldac_reg;
    logic frame_is_ref_reg;

    // Pulse starts with nsync rising and spans the first two SYNC_HIGH cycles; ref frames leave it high.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            nldac_reg        <= 1'b1;
            frame_is_ref_reg <= 1'b0;
        end else begin
            if (ref_grant || chan_grant)
                frame_is_ref_reg <= ref_grant;
            if (frame_end)
                nldac_reg <= frame_is_ref_reg;
            else if (state_reg == SYNC_HIGH && sync_cnt_reg == SYNC_W'(1))
                nldac_reg <= 1'b1;
        end
    end
    assign dac_nldac_out = nldac_reg;
`else
    assign dac_nldac_out = 1'b0;
`endif

    assign dac_nsync_out = nsync_reg;
    assign dac_sclk_out  = sclk_reg;
    assign dac_din_out   = din_reg;
    assign dac_nclr_out  = 1'b1;
    assign wr_done_out   = wr_done_reg;
    assign busy_out      = busy_reg;
endmodule

// File: tb/tb_dac_instr_serializer.sv
// Directed bench for dac_instr_serializer: decodes SPI frames on falling sclk and checks words, timing and arbitration.
module tb_dac_instr_serializer;
    localparam int N_CHAN   = 8;
    localparam int W_DATA   = 16;
    localparam int SCLK_DIV = 2;
    localparam int T_SYNC   = 4;
    localparam int LOW_CYC  = 64 * SCLK_DIV;
    localparam int PERIOD   = 1 + LOW_CYC + T_SYNC;
`ifdef DAC_LDAC_PULSE_EN
    localparam logic [31:0] CTRL_MASK  = 32'hF0FF_FFFF;
    localparam logic        NLDAC_IDLE = 1'b1;
`else
    localparam logic [31:0] CTRL_MASK  = 32'hFFFF_FFFF;
    localparam logic        NLDAC_IDLE = 1'b0;
`endif

    logic                     clk_in = 1'b0;
    logic                     reset_in = 1'b1;
    logic [N_CHAN-1:0]        data_valid_in = '0;
    logic [N_CHAN*W_DATA-1:0] data_in = '0;
    logic                     ref_set_in = 1'b0;
    logic dac_nsync_out, dac_sclk_out, dac_din_out, dac_nldac_out, dac_nclr_out, wr_done_out, busy_out;

    dac_instr_serializer #(.N_CHAN(N_CHAN), .W_DATA(W_DATA), .SCLK_DIV(SCLK_DIV), .T_SYNC(T_SYNC)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .data_valid_in(data_valid_in), .data_in(data_in),
        .ref_set_in(ref_set_in), .dac_nsync_out(dac_nsync_out), .dac_sclk_out(dac_sclk_out),
        .dac_din_out(dac_din_out), .dac_nldac_out(dac_nldac_out), .dac_nclr_out(dac_nclr_out),
        .wr_done_out(wr_done_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] word;
        int          falls;
        int          low;
        int          end_cyc;
    } frame_t;

    frame_t      frames[$];
    int          cyc = 0, cur_falls = 0, cur_low = 0, wr_cnt = 0;
    int          nldac_low_cnt = 0, nldac_high_cnt = 0, nldac_fall_cyc = -1;
    logic [31:0] cur_word = '0;
    logic        prev_sclk = 1'b1, prev_nsync = 1'b1, prev_nldac = 1'b1;
    int          total = 0, bad = 0;

    // Frame monitor: behaves like the DAC, shifting din in on every falling sclk while nsync is low.
    always @(negedge clk_in) begin
        frame_t f;
        cyc++;
        if (reset_in) begin
            cur_word = '0; cur_falls = 0; cur_low = 0;
            prev_sclk = 1'b1; prev_nsync = 1'b1;
        end else begin
            if (!dac_nsync_out) cur_low++;
            if (prev_sclk && !dac_sclk_out && !dac_nsync_out) begin
                cur_word = {cur_word[30:0], dac_din_out};
                cur_falls++;
            end
            if (!prev_nsync && dac_nsync_out) begin
                f.word = cur_word; f.falls = cur_falls; f.low = cur_low; f.end_cyc = cyc;
                frames.push_back(f);
                cur_word = '0; cur_falls = 0; cur_low = 0;
            end
            if (wr_done_out) wr_cnt++;
            prev_sclk  = dac_sclk_out;
            prev_nsync = dac_nsync_out;
        end
        if (!dac_nldac_out) begin
            nldac_low_cnt++;
            if (prev_nldac) nldac_fall_cyc = cyc;
        end else begin
            nldac_high_cnt++;
        end
        prev_nldac = dac_nldac_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames.size() < n && k < budget) begin
            @(negedge clk_in);
            k++;
        end
        total++;
        if (frames.size() < n) begin
            bad++;
            $display("FAIL frame_timeout: got %0d frames expected %0d", frames.size(), n);
        end
    endtask

    task automatic do_reset();
        @(posedge clk_in); #1 reset_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 reset_in = 1'b0;
    endtask

    task automatic strobe(input logic [N_CHAN-1:0] mask, input logic ref_req);
        @(posedge clk_in); #1;
        data_valid_in = mask;
        ref_set_in    = ref_req;
        @(posedge clk_in); #1;
        data_valid_in = '0;
        ref_set_in    = 1'b0;
    endtask

    typedef struct {
        int          ch;
        logic [15:0] code;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base, wr0, nl0, k;
        logic [31:0] exp_w;
        int rr_order[9];

        vecs[0] = '{0, 16'd13107, 32'h0303_3330};
        vecs[1] = '{2, 16'hABCD,  32'h032A_BCD0};
        vecs[2] = '{7, 16'hFFFF,  32'h037F_FFF0};
        vecs[3] = '{5, 16'h0001,  32'h0350_0010};
        vecs[4] = '{3, 16'h8000,  32'h0338_0000};
        vecs[5] = '{6, 16'd52428, 32'h036C_CCC0};
        rr_order = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

        repeat (3) @(posedge clk_in);
        #1 reset_in = 1'b0;
        @(negedge clk_in);
        check("rst_nsync", 32'(dac_nsync_out), 32'd1);
        check("rst_sclk", 32'(dac_sclk_out), 32'd1);
        check("rst_din", 32'(dac_din_out), 32'd0);
        check("rst_nldac", 32'(dac_nldac_out), 32'(NLDAC_IDLE));
        check("rst_nclr", 32'(dac_nclr_out), 32'd1);
        check("rst_wr_done", 32'(wr_done_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        $display("reset state checked");

        // Single writes, one per table entry.
        for (int i = 0; i < 6; i++) begin
            base = frames.size();
            wr0  = wr_cnt;
            data_in[vecs[i].ch*W_DATA +: W_DATA] = vecs[i].code;
            strobe(N_CHAN'(1) << vecs[i].ch, 1'b0);
            check("latency_hi", 32'(dac_nsync_out), 32'd1);
            @(posedge clk_in); #1;
            check("latency_lo", 32'(dac_nsync_out), 32'd0);
            check("busy_in_frame", 32'(busy_out), 32'd1);
            wait_frames(base + 1, 1000);
            if (frames.size() > base) begin
                check("word", frames[base].word, vecs[i].word & CTRL_MASK);
                check("falls", 32'(frames[base].falls), 32'd32);
                check("nsync_low", 32'(frames[base].low), 32'(LOW_CYC));
                $display("vec %0d ch %0d word %h", i, vecs[i].ch, frames[base].word);
            end
            repeat (T_SYNC + 4) @(negedge clk_in);
            check("wr_done_cnt", 32'(wr_cnt - wr0), 32'd1);
            check("idle_busy", 32'(busy_out), 32'd0);
            check("idle_din", 32'(dac_din_out), 32'd0);
        end

        // Ref set and channel 2 in the same cycle: ref goes first.
        base = frames.size();
        wr0  = wr_cnt;
        data_in[2*W_DATA +: W_DATA] = 16'h1234;
        strobe(8'h04, 1'b1);
        wait_frames(base + 2, 2000);
        if (frames.size() > base + 1) begin
            check("ref_word", frames[base].word, 32'h0800_0001);
            check("ref_then_ch2", frames[base+1].word, 32'h0321_2340 & CTRL_MASK);
            $display("ref frame %h then %h", frames[base].word, frames[base+1].word);
        end
        repeat (T_SYNC + 4) @(negedge clk_in);
        check("ref_wr_done_cnt", 32'(wr_cnt - wr0), 32'd2);

        // Coalescing: three channel 5 codes during a channel 0 frame collapse into one frame.
        base = frames.size();
        data_in[0*W_DATA +: W_DATA] = 16'h0AAA;
        strobe(8'h01, 1'b0);
        k = 0;
        while (dac_nsync_out && k < 20) begin @(negedge clk_in); k++; end
        data_in[5*W_DATA +: W_DATA] = 16'd100; strobe(8'h20, 1'b0);
        data_in[5*W_DATA +: W_DATA] = 16'd200; strobe(8'h20, 1'b0);
        data_in[5*W_DATA +: W_DATA] = 16'd300; strobe(8'h20, 1'b0);
        wait_frames(base + 2, 2000);
        repeat (300) @(negedge clk_in);
        check("coalesce_frames", 32'(frames.size() - base), 32'd2);
        if (frames.size() > base + 1) begin
            check("coalesce_ch0", frames[base].word, 32'h0300_AAA0 & CTRL_MASK);
            check("coalesce_ch5", frames[base+1].word, 32'h0350_12C0 & CTRL_MASK);
            $display("coalesce frames %h %h", frames[base].word, frames[base+1].word);
        end

        // Round-robin after reset: all channels at once, channel 0 again mid-sequence.
        do_reset();
        base = frames.size();
        wr0  = wr_cnt;
        for (int n = 0; n < N_CHAN; n++) data_in[n*W_DATA +: W_DATA] = 16'h1000 + 16'(n);
        strobe(8'hFF, 1'b0);
        wait_frames(base + 3, 1000);
        data_in[0*W_DATA +: W_DATA] = 16'h2000;
        strobe(8'h01, 1'b0);
        wait_frames(base + 9, 3000);
        repeat (300) @(negedge clk_in);
        check("rr_frames", 32'(frames.size() - base), 32'd9);
        check("rr_wr_done_cnt", 32'(wr_cnt - wr0), 32'd9);
        if (frames.size() >= base + 9) begin
            for (int j = 0; j < 9; j++) begin
                if (j == 8) exp_w = 32'h0302_0000;
                else        exp_w = {8'h03, 4'(rr_order[j]), 16'h1000 + 16'(rr_order[j]), 4'h0};
                check("rr_word", frames[base+j].word, exp_w & CTRL_MASK);
                $display("rr slot %0d word %h", j, frames[base+j].word);
            end
            check("frame_period", 32'(frames[base+1].end_cyc - frames[base].end_cyc), 32'(PERIOD));
        end

        // Reset after the 10th falling edge aborts the frame and drops everything pending.
        base = frames.size();
        wr0  = wr_cnt;
        data_in[1*W_DATA +: W_DATA] = 16'h5555;
        strobe(8'h02, 1'b0);
        data_in[4*W_DATA +: W_DATA] = 16'h4444;
        strobe(8'h10, 1'b0);
        k = 0;
        while (cur_falls < 10 && k < 500) begin @(negedge clk_in); k++; end
        check("abort_reached_10", 32'(cur_falls), 32'd10);
        @(posedge clk_in); #1 reset_in = 1'b1;
        @(posedge clk_in); #1;
        check("abort_nsync", 32'(dac_nsync_out), 32'd1);
        check("abort_sclk", 32'(dac_sclk_out), 32'd1);
        check("abort_busy", 32'(busy_out), 32'd0);
        check("abort_wr_done", 32'(wr_done_out), 32'd0);
        reset_in = 1'b0;
        repeat (400) @(negedge clk_in);
        check("abort_no_frame", 32'(frames.size() - base), 32'd0);
        check("abort_no_wr_done", 32'(wr_cnt - wr0), 32'd0);
        $display("reset mid-frame checked");

`ifdef DAC_LDAC_PULSE_EN
        base = frames.size();
        nl0  = nldac_low_cnt;
        data_in[1*W_DATA +: W_DATA] = 16'd52428;
        strobe(8'h02, 1'b0);
        wait_frames(base + 1, 1000);
        repeat (T_SYNC + 4) @(negedge clk_in);
        if (frames.size() > base) begin
            check("ldac_word", frames[base].word, 32'h001C_CCC0);
            check("ldac_start", 32'(nldac_fall_cyc), 32'(frames[base].end_cyc));
        end
        check("ldac_width", 32'(nldac_low_cnt - nl0), 32'd2);
        base = frames.size();
        nl0  = nldac_low_cnt;
        strobe('0, 1'b1);
        wait_frames(base + 1, 1000);
        repeat (T_SYNC + 4) @(negedge clk_in);
        check("ldac_ref_none", 32'(nldac_low_cnt - nl0), 32'd0);
        $display("ldac pulse checked");
`else
        check("nldac_never_high", 32'(nldac_high_cnt), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
